// File: rtl/multioper_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Package  : multioper_pkg                                           |
// | Purpose  : Shared widths, types and helpers for the sign-magnitude |
// |            multiplier (multioper_sm).                              |
// | Contents : MAG_W_DEFAULT - default operand magnitude width         |
// |            OPW / PW      - operand / product widths               |
// |            sm_operand_t, sm_product_t, sign_of()                   |
// | Options  : none (MULTIOPER_ZF_EN is handled by the users)          |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
package multioper_pkg;

   localparam int MAG_W_DEFAULT = 2;
   localparam int OPW           = MAG_W_DEFAULT + 1;
   localparam int PW            = 2 * MAG_W_DEFAULT + 1;

   typedef logic [OPW-1:0] sm_operand_t;
   typedef logic [PW-1:0]  sm_product_t;

   // Sign bit of a default-width sign-magnitude operand (1 = negative).
   function automatic logic sign_of(input sm_operand_t op);
      return op[OPW-1];
   endfunction

endpackage : multioper_pkg
`default_nettype wire

// File: rtl/multioper_sm_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Interface: multioper_sm_if                                         |
// | Purpose  : Operand/result bundle of the sign-magnitude multiplier. |
// | Signals  : in_valid, a, b   - operand pair (master -> slave)       |
// |            out_valid, p     - registered product (slave -> master) |
// |            zf               - product-magnitude-zero flag, only    |
// |                               when MULTIOPER_ZF_EN is defined      |
// | Options  : MULTIOPER_ZF_EN                                         |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
interface multioper_sm_if
   import multioper_pkg::*;
#(
   parameter int MAG_W = MAG_W_DEFAULT
);
   logic               in_valid;
   logic [MAG_W:0]     a;
   logic [MAG_W:0]     b;
   logic               out_valid;
   logic [2*MAG_W:0]   p;
`ifdef MULTIOPER_ZF_EN
   logic               zf;
`endif

   modport master (
      output in_valid, a, b,
      input  out_valid, p
`ifdef MULTIOPER_ZF_EN
      , input zf
`endif
   );

   modport slave (
      input  in_valid, a, b,
      output out_valid, p
`ifdef MULTIOPER_ZF_EN
      , output zf
`endif
   );
endinterface : multioper_sm_if
`default_nettype wire

// File: rtl/multioper_sm_mul_core.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : sm_mul_core                                             |
// | Purpose  : Combinational sign-magnitude multiply.                  |
// | Ports    : a, b  (in)  - MAG_W+1 bit operands, sign in MSB         |
// |            p     (out) - 2*MAG_W+1 bit product, sign in MSB        |
// |            zero  (out) - product magnitude is 0 (MULTIOPER_ZF_EN)  |
// | Options  : MULTIOPER_ZF_EN adds the zero output                    |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module sm_mul_core
   import multioper_pkg::*;
#(
   parameter int MAG_W = MAG_W_DEFAULT
) (
   input  wire logic [MAG_W:0]   a,
   input  wire logic [MAG_W:0]   b,
`ifdef MULTIOPER_ZF_EN
   output logic                  zero,
`endif
   output logic [2*MAG_W:0]      p
);

   // Magnitudes are widened to the full product width before multiplying
   // so the multiply is evaluated at 2*MAG_W bits and never truncates.
   logic [2*MAG_W-1:0] w_a_mag;
   logic [2*MAG_W-1:0] w_b_mag;
   logic [2*MAG_W-1:0] w_mag;
   logic               w_sign;

   assign w_a_mag = {{MAG_W{1'b0}}, a[MAG_W-1:0]};
   assign w_b_mag = {{MAG_W{1'b0}}, b[MAG_W-1:0]};
   assign w_mag   = w_a_mag * w_b_mag;

   // Sign is a plain XOR; a zero magnitude keeps its sign (no -0 cleanup).
   assign w_sign  = a[MAG_W] ^ b[MAG_W];

   assign p       = {w_sign, w_mag};

`ifdef MULTIOPER_ZF_EN
   assign zero    = (w_mag == '0);
`endif

endmodule : sm_mul_core
`default_nettype wire

// File: rtl/multioper_sm.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : multioper_sm                                            |
// | Purpose  : Registered sign-magnitude multiplier, 1-cycle latency.  |
// | Ports    : clk    - rising-edge clock                              |
// |            rst_n  - asynchronous active-low reset                  |
// |            bus    - multioper_sm_if.slave:                         |
// |                     in_valid, a, b -> out_valid, p (, zf)          |
// | Options  : MULTIOPER_ZF_EN adds registered zero flag bus.zf        |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module multioper_sm
   import multioper_pkg::*;
#(
   parameter int MAG_W = MAG_W_DEFAULT
) (
   input  wire logic        clk,
   input  wire logic        rst_n,
   multioper_sm_if.slave    bus
);

   logic [2*MAG_W:0] w_p;
   logic [2*MAG_W:0] r_p;
   logic             r_valid;
`ifdef MULTIOPER_ZF_EN
   logic             w_zf;
   logic             r_zf;
`endif

   sm_mul_core #(
      .MAG_W (MAG_W)
   ) u_core (
      .a    (bus.a),
      .b    (bus.b),
`ifdef MULTIOPER_ZF_EN
      .zero (w_zf),
`endif
      .p    (w_p)
   );

   // Valid follows in_valid every edge; the result registers only load
   // on accepted operands so p (and zf) hold across idle cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_p     <= '0;
         r_valid <= 1'b0;
`ifdef MULTIOPER_ZF_EN
         r_zf    <= 1'b0;
`endif
      end else begin
         r_valid <= bus.in_valid;
         if (bus.in_valid) begin
            r_p  <= w_p;
`ifdef MULTIOPER_ZF_EN
            r_zf <= w_zf;
`endif
         end
      end
   end

   assign bus.p         = r_p;
   assign bus.out_valid = r_valid;
`ifdef MULTIOPER_ZF_EN
   assign bus.zf        = r_zf;
`endif

endmodule : multioper_sm
`default_nettype wire

// File: tb/tb_multioper_sm.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_multioper_sm                                         |
// | Purpose  : Directed self-checking bench for multioper_sm (MAG_W=2).|
// | Options  : MULTIOPER_ZF_EN enables the zf checks                   |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module tb_multioper_sm;
   import multioper_pkg::*;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_pass;

   multioper_sm_if #(.MAG_W(2)) bus ();

   multioper_sm #(
      .MAG_W (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Apply inputs on the falling edge, away from the sampling edge.
   task automatic drive(input logic v, input logic [2:0] av, input logic [2:0] bv);
      @(negedge clk);
      bus.in_valid = v;
      bus.a        = av;
      bus.b        = bv;
   endtask

   // Move past the next rising edge and let outputs settle.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [2:0] ea, eb;
   logic [4:0] exp_p;

   initial begin
      n_checks = 0;
      n_pass   = 0;
      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      bus.a        = '0;
      bus.b        = '0;

      // Reset state
      #1;
      check("reset_p", 32'(bus.p), 32'h00);
      check("reset_valid", 32'(bus.out_valid), 32'h0);
      step();
      @(negedge clk);
      rst_n = 1'b1;

      // Basic product 3*3 = 9
      drive(1'b1, 3'b011, 3'b011);
      step();
      check("basic_p", 32'(bus.p), 32'b01001);
      check("basic_valid", 32'(bus.out_valid), 32'h1);
      drive(1'b0, 3'b000, 3'b000);
      step();
      check("hold_valid", 32'(bus.out_valid), 32'h0);
      check("hold_p", 32'(bus.p), 32'b01001);

      // Sign rules
      drive(1'b1, 3'b111, 3'b011);
      step();
      check("sign_neg_pos", 32'(bus.p), 32'b11001);
      drive(1'b1, 3'b111, 3'b111);
      step();
      check("sign_neg_neg", 32'(bus.p), 32'b01001);
      drive(1'b1, 3'b010, 3'b101);
      step();
      check("sign_pos_neg", 32'(bus.p), 32'b10010);

      // Negative zero keeps its sign
      drive(1'b1, 3'b100, 3'b000);
      step();
      check("neg_zero_p", 32'(bus.p), 32'b10000);
`ifdef MULTIOPER_ZF_EN
      check("neg_zero_zf", 32'(bus.zf), 32'h1);
      drive(1'b1, 3'b001, 3'b001);
      step();
      check("one_p", 32'(bus.p), 32'b00001);
      check("one_zf", 32'(bus.zf), 32'h0);
`endif

      // Reset asserted mid-stream with operands pending
      drive(1'b1, 3'b011, 3'b011);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_p", 32'(bus.p), 32'h00);
      check("midrst_valid", 32'(bus.out_valid), 32'h0);
`ifdef MULTIOPER_ZF_EN
      check("midrst_zf", 32'(bus.zf), 32'h0);
`endif
      step();
      check("inrst_p", 32'(bus.p), 32'h00);
      check("inrst_valid", 32'(bus.out_valid), 32'h0);
      @(negedge clk);
      rst_n        = 1'b1;
      bus.in_valid = 1'b0;
      step();
      check("postrst_valid", 32'(bus.out_valid), 32'h0);
      check("postrst_p", 32'(bus.p), 32'h00);

      // Exhaustive, back-to-back
      for (int i = 0; i < 64; i++) begin
         ea = 3'(i >> 3);
         eb = 3'(i);
         drive(1'b1, ea, eb);
         step();
         exp_p[4]   = sign_of(sm_operand_t'(ea)) ^ sign_of(sm_operand_t'(eb));
         exp_p[3:0] = 4'(int'(ea[1:0]) * int'(eb[1:0]));
         check($sformatf("exh_sign_%0d", i), 32'(bus.p[4]), 32'(exp_p[4]));
         check($sformatf("exh_mag_%0d", i), 32'(bus.p[3:0]), 32'(exp_p[3:0]));
         check($sformatf("exh_valid_%0d", i), 32'(bus.out_valid), 32'h1);
`ifdef MULTIOPER_ZF_EN
         check($sformatf("exh_zf_%0d", i), 32'(bus.zf), 32'(exp_p[3:0] == 4'd0));
`endif
      end

      // Idle after stream: last result (7*7 -> +9) holds
      drive(1'b0, 3'b000, 3'b000);
      step();
      check("end_valid", 32'(bus.out_valid), 32'h0);
      check("end_p", 32'(bus.p), 32'b01001);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_multioper_sm
`default_nettype wire
